// File: rtl/pipe_stage_skid.sv
// Handshaked pipeline stage register with a 2-entry skid buffer, synchronous
// flush and a saturating back-pressure counter.
module pipe_stage_skid #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned CTRL_W = 19,
   parameter int unsigned CNT_W  = 16
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic              flush,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   localparam int unsigned ENT_W = DATA_W + CTRL_W;

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_ONE   = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_nxt;
   logic [ENT_W-1:0]   r_head;
   logic [ENT_W-1:0]   r_skid;
   logic [ENT_W-1:0]   w_head_nxt;
   logic [ENT_W-1:0]   w_skid_nxt;
   logic [ENT_W-1:0]   w_in_ent;
   logic [CNT_W-1:0]   r_stall_cnt;
   logic               w_in_ready;
   logic               w_out_valid;
   logic               w_in_fire;
   logic               w_out_fire;

   // Both handshake qualifiers depend only on registered state, never on out_ready.
   assign w_in_ready  = (r_state != S_FULL);
   assign w_out_valid = (r_state != S_EMPTY);
   assign w_in_ent    = {in_data, in_ctrl};
   assign w_in_fire   = in_valid  & w_in_ready  & ~flush;
   assign w_out_fire  = w_out_valid & out_ready & ~flush;

   always_comb begin
      w_state_nxt = r_state;
      w_head_nxt  = r_head;
      w_skid_nxt  = r_skid;
      if (flush) begin
         w_state_nxt = S_EMPTY;
         w_head_nxt  = '0;
         w_skid_nxt  = '0;
      end else begin
         unique case (r_state)
            S_EMPTY: begin
               if (w_in_fire) begin
                  w_state_nxt = S_ONE;
                  w_head_nxt  = w_in_ent;
               end
            end
            S_ONE: begin
               if (w_in_fire && w_out_fire) begin
                  w_head_nxt = w_in_ent;
               end else if (w_in_fire) begin
                  w_state_nxt = S_FULL;
                  w_skid_nxt  = w_in_ent;
               end else if (w_out_fire) begin
                  w_state_nxt = S_EMPTY;
               end
            end
            S_FULL: begin
               if (w_out_fire) begin
                  w_state_nxt = S_ONE;
                  w_head_nxt  = r_skid;
               end
            end
            default: w_state_nxt = S_EMPTY;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_state <= S_EMPTY;
         r_head  <= '0;
         r_skid  <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_head  <= w_head_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         r_stall_cnt <= '0;
      end else if (w_out_valid && !out_ready && !flush && (r_stall_cnt != '1)) begin
         r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end
   end

   always_comb begin
      occupancy = 2'd0;
      unique case (r_state)
         S_EMPTY: occupancy = 2'd0;
         S_ONE:   occupancy = 2'd1;
         S_FULL:  occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = w_out_valid ? r_head[ENT_W-1:CTRL_W] : '0;
   assign out_ctrl  = w_out_valid ? r_head[CTRL_W-1:0]     : '0;
   assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: directed scenarios plus randomized traffic, all
// checked against a queue-based model of the stage.
module tb_pipe_stage_skid;

   localparam int unsigned DW = 32;
   localparam int unsigned CW = 19;

   logic          CLK = 1'b0;
   logic          nRST = 1'b0;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [CW-1:0] in_ctrl = '0;
   logic          flush = 1'b0;
   logic          out_ready = 1'b0;

   logic          in_ready, out_valid;
   logic [DW-1:0] out_data;
   logic [CW-1:0] out_ctrl;
   logic [1:0]    occupancy;
   logic [15:0]   stall_cnt;

   logic          s_in_ready, s_out_valid;
   logic [DW-1:0] s_out_data;
   logic [CW-1:0] s_out_ctrl;
   logic [1:0]    s_occupancy;
   logic [3:0]    s_stall_cnt;

   int unsigned checks = 0;
   int unsigned errors = 0;

   // model: queue of held entries and the two counters
   logic [DW+CW-1:0] mq[$];
   int unsigned      m_cnt;
   int unsigned      m_cnt4;

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) u_dut (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_ctrl(out_ctrl), .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   pipe_stage_skid #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4)) u_sat (
      .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(s_in_ready),
      .in_data(in_data), .in_ctrl(in_ctrl), .flush(flush),
      .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
      .out_ctrl(s_out_ctrl), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   function automatic logic e_valid();
      return mq.size() > 0;
   endfunction
   function automatic logic e_ready();
      return mq.size() < 2;
   endfunction
   function automatic logic [DW-1:0] e_data();
      logic [DW+CW-1:0] h;
      h = (mq.size() > 0) ? mq[0] : '0;
      return h[DW+CW-1:CW];
   endfunction
   function automatic logic [CW-1:0] e_ctrl();
      logic [DW+CW-1:0] h;
      h = (mq.size() > 0) ? mq[0] : '0;
      return h[CW-1:0];
   endfunction

   task automatic m_reset();
      mq.delete();
      m_cnt  = 0;
      m_cnt4 = 0;
   endtask

   // one rising edge: advance the model with the inputs seen at that edge
   task automatic tick();
      int unsigned sz;
      @(posedge CLK);
      if (nRST) begin
         sz = mq.size();
         if (flush) begin
            mq.delete();
         end else begin
            if (sz > 0 && !out_ready) begin
               if (m_cnt  < 65535) m_cnt++;
               if (m_cnt4 < 15)    m_cnt4++;
            end
            if (sz > 0 && out_ready) void'(mq.pop_front());
            if (in_valid && sz < 2) mq.push_back({in_data, in_ctrl});
         end
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                        input logic ordy, input logic fl);
      in_valid  = v;
      in_data   = d;
      in_ctrl   = c;
      out_ready = ordy;
      flush     = fl;
   endtask

   task automatic test_reset();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      nRST = 1'b0;
      #3;
      m_reset();
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data got %h exp 0", out_data); end
      checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl got %h exp 0", out_ctrl); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL reset_occupancy got %0d exp 0", occupancy); end
      checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall_cnt got %0d exp 0", stall_cnt); end
      nRST = 1'b1;
   endtask

   task automatic test_stream();
      for (int i = 1; i <= 3; i++) begin
         drive(1'b1, DW'(i), CW'(i * 16), 1'b1, 1'b0);
         tick();
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %b exp 1", i, out_valid); end
         checks++; if (out_data !== DW'(i)) begin errors++; $display("FAIL stream_data[%0d] got %h exp %h", i, out_data, DW'(i)); end
         checks++; if (out_ctrl !== CW'(i * 16)) begin errors++; $display("FAIL stream_ctrl[%0d] got %h exp %h", i, out_ctrl, CW'(i * 16)); end
         checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL stream_occ[%0d] got %0d exp 1", i, occupancy); end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d] got %b exp 1", i, in_ready); end
         checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stream_stall[%0d] got %0d exp 0", i, stall_cnt); end
      end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_drain_valid got %b exp 0", out_valid); end
   endtask

   task automatic test_backpressure();
      int unsigned c0;
      c0 = m_cnt;
      drive(1'b1, 32'hA, 19'hA0, 1'b0, 1'b0);
      tick();
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL bp_occ1 got %0d exp 1", occupancy); end
      checks++; if (out_data !== 32'hA) begin errors++; $display("FAIL bp_head_a got %h exp a", out_data); end
      drive(1'b1, 32'hB, 19'hB0, 1'b0, 1'b0);
      tick();
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL bp_occ2 got %0d exp 2", occupancy); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", in_ready); end
      checks++; if (stall_cnt !== 16'(c0 + 1)) begin errors++; $display("FAIL bp_stall1 got %0d exp %0d", stall_cnt, c0 + 1); end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick();
      checks++; if (stall_cnt !== 16'(c0 + 2)) begin errors++; $display("FAIL bp_stall2 got %0d exp %0d", stall_cnt, c0 + 2); end
      checks++; if (out_data !== 32'hA) begin errors++; $display("FAIL bp_head_hold got %h exp a", out_data); end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
      checks++; if (out_data !== 32'hB || out_ctrl !== 19'hB0) begin errors++; $display("FAIL bp_head_b got %h/%h exp b/b0", out_data, out_ctrl); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_in_ready_back got %b exp 1", in_ready); end
      checks++; if (stall_cnt !== 16'(c0 + 2)) begin errors++; $display("FAIL bp_stall_hold got %0d exp %0d", stall_cnt, c0 + 2); end
      tick();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL bp_empty got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
   endtask

   task automatic test_simultaneous();
      drive(1'b1, 32'h5, 19'h50, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h6, 19'h60, 1'b1, 1'b0);
      tick();
      checks++; if (out_data !== 32'h6) begin errors++; $display("FAIL simul_head got %h exp 6", out_data); end
      checks++; if (occupancy !== 2'd1) begin errors++; $display("FAIL simul_occ got %0d exp 1", occupancy); end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tick();
   endtask

   task automatic test_flush();
      drive(1'b1, 32'hC, 19'hC0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'hD, 19'hD0, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'hE, 19'hE0, 1'b1, 1'b1);
      tick();
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", out_valid); end
      checks++; if (out_data !== '0) begin errors++; $display("FAIL flush_data got %h exp 0", out_data); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL flush_occ got %0d exp 0", occupancy); end
      checks++; if (stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL flush_stall got %0d exp %0d", stall_cnt, m_cnt); end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_valid !== 1'b0 || out_data === 32'hE) begin errors++; $display("FAIL flush_no_e[%0d] got v=%b d=%h exp v=0", i, out_valid, out_data); end
      end
   endtask

   task automatic test_saturation();
      drive(1'b1, 32'h77, 19'h7, 1'b0, 1'b0);
      tick();
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      repeat (20) tick();
      checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_cnt got %0d exp 15", s_stall_cnt); end
      checks++; if (stall_cnt !== 16'(m_cnt)) begin errors++; $display("FAIL sat_wide_cnt got %0d exp %0d", stall_cnt, m_cnt); end
      tick();
      checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_hold got %0d exp 15", s_stall_cnt); end
      drive(1'b0, '0, '0, 1'b0, 1'b1);
      tick();
      checks++; if (s_stall_cnt !== 4'd15) begin errors++; $display("FAIL sat_after_flush got %0d exp 15", s_stall_cnt); end
      checks++; if (s_occupancy !== 2'd0 || s_out_valid !== 1'b0) begin errors++; $display("FAIL sat_flush_occ got %0d/%b exp 0/0", s_occupancy, s_out_valid); end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 3) != 0), DW'($urandom), CW'($urandom),
               ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
         tick();
         checks++; if (out_valid !== e_valid() || in_ready !== e_ready() || occupancy !== 2'(mq.size())) begin
            errors++; $display("FAIL rand_flags[%0d] got v=%b r=%b occ=%0d exp v=%b r=%b occ=%0d", i, out_valid, in_ready, occupancy, e_valid(), e_ready(), mq.size());
         end
         checks++; if (out_data !== e_data() || out_ctrl !== e_ctrl()) begin
            errors++; $display("FAIL rand_payload[%0d] got %h/%h exp %h/%h", i, out_data, out_ctrl, e_data(), e_ctrl());
         end
         checks++; if (stall_cnt !== 16'(m_cnt) || s_stall_cnt !== 4'(m_cnt4)) begin
            errors++; $display("FAIL rand_stall[%0d] got %0d/%0d exp %0d/%0d", i, stall_cnt, s_stall_cnt, m_cnt, m_cnt4);
         end
         checks++; if (s_out_valid !== e_valid() || s_in_ready !== e_ready() || s_out_data !== e_data() || s_out_ctrl !== e_ctrl()) begin
            errors++; $display("FAIL rand_sat_inst[%0d] got v=%b r=%b d=%h c=%h exp v=%b r=%b d=%h c=%h", i, s_out_valid, s_in_ready, s_out_data, s_out_ctrl, e_valid(), e_ready(), e_data(), e_ctrl());
         end
      end
      drive(1'b0, '0, '0, 1'b0, 1'b0);
   endtask

   task automatic test_async_reset();
      drive(1'b1, 32'h91, 19'h1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 32'h92, 19'h2, 1'b0, 1'b0);
      tick();
      checks++; if (occupancy !== 2'd2) begin errors++; $display("FAIL arst_pre_full got %0d exp 2", occupancy); end
      #2;
      nRST = 1'b0;
      #1;
      m_reset();
      checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL arst_flags got r=%b v=%b exp r=1 v=0", in_ready, out_valid); end
      checks++; if (out_data !== '0 || out_ctrl !== '0) begin errors++; $display("FAIL arst_payload got %h/%h exp 0/0", out_data, out_ctrl); end
      checks++; if (occupancy !== 2'd0) begin errors++; $display("FAIL arst_occ got %0d exp 0", occupancy); end
      checks++; if (stall_cnt !== 16'd0 || s_stall_cnt !== 4'd0) begin errors++; $display("FAIL arst_stall got %0d/%0d exp 0/0", stall_cnt, s_stall_cnt); end
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      @(negedge CLK);
      nRST = 1'b1;
      tick();
      checks++; if (out_valid !== 1'b0 || occupancy !== 2'd0) begin errors++; $display("FAIL arst_no_partial got v=%b occ=%0d exp v=0 occ=0", out_valid, occupancy); end
   endtask

   initial begin
      m_reset();
      test_reset();
      test_stream();
      test_backpressure();
      test_simultaneous();
      test_flush();
      test_saturation();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
